// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter for the single Avalon-MM port of the packet RAM.
// Grants one master at a time, caps bursts while the other waits, and routes read data back to its issuer.
module ram_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int MAX_BURST    = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_original,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic [3:0]        m0_byteenable,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    input  logic [3:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_read,
    output logic [31:0]       ram_writedata,
    output logic [3:0]        ram_byteenable,
    input  logic [31:0]       ram_readdata,
    input  logic              ram_waitrequest,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // State encoding doubles as the one-hot grant, so grant is the visible FSM state.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t                  state_q, state_next;
    logic                    last_grant;
    logic [CNT_W-1:0]        burst_cnt;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_id;
    logic                    req0, req1, complete, cap_hit;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign complete = ram_chipselect & ~ram_waitrequest;
    assign cap_hit  = (burst_cnt + 1'b1) == CNT_W'(MAX_BURST);
    assign grant    = state_q;

    // Avalon handshake: a transfer completes on the cycle the granted master holds read/write
    // and ram_waitrequest is low; a stalled master must hold address/data/strobes stable.
    always_comb begin
        ram_addr       = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_read       = 1'b0;
        ram_writedata  = '0;
        ram_byteenable = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            GRANT0: begin
                ram_addr       = m0_address;
                ram_chipselect = req0;
                ram_write      = m0_write;
                ram_read       = m0_read;
                ram_writedata  = m0_writedata;
                ram_byteenable = m0_byteenable;
                m0_waitrequest = ram_waitrequest;
            end
            GRANT1: begin
                ram_addr       = m1_address;
                ram_chipselect = req1;
                ram_write      = m1_write;
                ram_read       = m1_read;
                ram_writedata  = m1_writedata;
                ram_byteenable = m1_byteenable;
                m1_waitrequest = ram_waitrequest;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1)  state_next = last_grant ? GRANT0 : GRANT1;
                else if (req0)     state_next = GRANT0;
                else if (req1)     state_next = GRANT1;
            end
            GRANT0: begin
                if (!req0)                           state_next = req1 ? GRANT1 : IDLE;
                else if (complete && req1 && cap_hit) state_next = GRANT1;
            end
            GRANT1: begin
                if (!req1)                           state_next = req0 ? GRANT0 : IDLE;
                else if (complete && req0 && cap_hit) state_next = GRANT0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state_q <= state_next;
            if (state_q == GRANT0 && state_next != GRANT0) last_grant <= 1'b0;
            if (state_q == GRANT1 && state_next != GRANT1) last_grant <= 1'b1;
            if (state_q == IDLE || state_next != state_q) burst_cnt <= '0;
            else if (complete)                            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Read-return pipeline tracks {valid, issuer} independently of the current grant.
    always_ff @(posedge clk_original or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_id    <= '0;
        end else begin
            pipe_valid[0] <= complete & ram_read;
            pipe_id[0]    <= (state_q == GRANT1);
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = pipe_valid[READ_LATENCY-1] & ~pipe_id[READ_LATENCY-1];
    assign m1_readdatavalid = pipe_valid[READ_LATENCY-1] &  pipe_id[READ_LATENCY-1];

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter for the single 32-bit Avalon-MM port of the on-chip packet RAM (1024 words). Sits between the RAM and its two users: master 0 (receive-path packet writer) and master 1 (transmit/readback path). It grants one master at a time with round-robin fairness and a burst cap, forwards the granted master's transfer to the RAM, and returns read data to the master that issued the read.

## Interface
- ADDR_W, 10, word address width
- MAX_BURST, 16, max consecutive completed transfers per grant while the other master waits (≥1)
- READ_LATENCY, 1, fixed RAM read latency in cycles (1..4)
- clk_original  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mN_address  in  ADDR_W  master N word address (N = 0, 1, same set per master)
- mN_read / mN_write  in  1  master N read/write request (never both high)
- mN_writedata  in  32  write data
- mN_byteenable  in  4  byte enables
- mN_waitrequest  out  1  stall to master N
- mN_readdata  out  32  read data (ram_readdata broadcast)
- mN_readdatavalid  out  1  read data valid for master N
- ram_addr  out  ADDR_W  RAM address
- ram_chipselect / ram_write / ram_read  out  1  RAM strobes
- ram_writedata  out  32; ram_byteenable  out  4
- ram_readdata  in  32; ram_waitrequest  in  1
- grant  out  2  one-hot current grant (bit N = master N), 0 when idle

## Operation
- States: IDLE, GRANT0, GRANT1 (registered). last_grant register, reset 1, so master 0 wins the first tie.
- reqN = mN_read | mN_write. Transfer completes on a cycle with ram_chipselect & ~ram_waitrequest.
- IDLE: only req0 → GRANT0; only req1 → GRANT1; both → grant the master ≠ last_grant; none → stay.
- GRANTn: RAM signals are driven combinationally from master n; ram_chipselect = reqn; mn_waitrequest = ram_waitrequest; other master's waitrequest = 1.
- burst_cnt increments on each completion in GRANTn; cleared on every grant change and in IDLE.
- On completion in GRANTn: if other master requests and burst_cnt+1 == MAX_BURST → switch to other grant; else if other master requests and reqn is low next cycle → handled below; else stay.
- In GRANTn with reqn low (no pending transfer): other requests → switch to other grant; else → IDLE. last_grant ← n whenever GRANTn is left.
- IDLE/ungranted: ram_chipselect/read/write = 0, ram_addr/writedata = 0, ram_byteenable = 0, both waitrequests = 1.
- Read return: shift register of depth READ_LATENCY carrying {valid, master id}; a completed read enters with valid=1. mN_readdatavalid = tail.valid & (tail.id == N). Writes enter valid=0.
- Read pipeline keeps advancing across grant changes; data returns to the issuer even if the grant has moved.

## Timing
- Reset values: state IDLE, grant 0, burst_cnt 0, last_grant 1, pipeline cleared; all RAM strobes 0; both mN_waitrequest 1; both mN_readdatavalid 0.
- Grant latency: request seen in IDLE → grant registered next edge → first transfer may complete that cycle (min 1 wait cycle from IDLE).
- Switch GRANT0→GRANT1 is direct (no IDLE cycle); other master's first transfer may complete in the first cycle of its grant.
- Read data: mN_readdatavalid asserted exactly READ_LATENCY cycles after the completion edge, one cycle wide per read.
- Back-to-back: granted master with ram_waitrequest = 0 completes one transfer per cycle.
- rst mid-transfer: all state cleared immediately; pending reads are discarded (no readdatavalid after reset).
- MAX_BURST = 1 → strict alternation when both request continuously.

## Test plan
- Reset: assert rst mid-burst with reads in flight → grant 0, strobes 0, waitrequests 1, no readdatavalid afterwards.
- Single master: m0 writes 0xA5A5_0001 to addr 5 then reads addr 5 (READ_LATENCY=1) → write after 1 wait cycle, m0_readdatavalid 1 cycle after read completion with 0xA5A5_0001, m1 signals untouched.
- Tie from IDLE: both request in the same cycle after reset → master 0 granted first; next tie after releasing → master 1.
- Burst cap: MAX_BURST=16, both request continuously, ram_waitrequest=0 → 16 completions for m0, then 16 for m1, alternating, no idle cycles between.
- RAM stall: ram_waitrequest held high 5 cycles during m1 read → m1_waitrequest high for those cycles, address/strobes stable, grant unchanged, m0 stays stalled.
- Read return across switch: m0 issues last read of its burst and grant moves to m1 → m0_readdatavalid (not m1) asserted READ_LATENCY cycles later.
